// File: rtl/seq_ram_ctrl.sv
// ---------------------------------------------------------------------------
// seq_ram_ctrl
//
// Controller for one sequence RAM of the Needleman-Wunsch engine. Owns the
// RAM write port and loads one sequence byte by byte. Arbitrates the single
// registered RAM read port between the fill engine (f_*) and the traceback
// engine (t_*), and returns read data to whichever requester was granted.
//
// Parameters
//   N    : sequence RAM depth (maximum sequence length)
//   Bit  : RAM address width, $clog2(N)
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : pulse that begins a new sequence load
//   ld_valid/ld_data/ld_last, ld_ready : byte loader handshake
//   seq_loaded, seq_len : sequence stored flag and length
//   f_req/f_addr/f_gnt, f_rvalid/f_rdata : fill read channel
//   t_req/t_addr/t_gnt, t_rvalid/t_rdata : traceback read channel
//   rd_err              : sticky flag, a granted address was >= seq_len
//   ram_en_din, ram_we, ram_addr_din, ram_din : RAM write port
//   ram_en_dout, ram_addr_dout, ram_dout      : RAM read port (1-cycle)
// ---------------------------------------------------------------------------
module seq_ram_ctrl #(
    parameter  int N   = 128,
    localparam int Bit = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           ld_valid,
    input  logic [7:0]     ld_data,
    input  logic           ld_last,
    output logic           ld_ready,
    output logic           seq_loaded,
    output logic [Bit:0]   seq_len,
    input  logic           f_req,
    input  logic [Bit-1:0] f_addr,
    input  logic           t_req,
    input  logic [Bit-1:0] t_addr,
    output logic           f_gnt,
    output logic           t_gnt,
    output logic           f_rvalid,
    output logic           t_rvalid,
    output logic [7:0]     f_rdata,
    output logic [7:0]     t_rdata,
    output logic           rd_err,
    output logic           ram_en_din,
    output logic           ram_we,
    output logic [Bit-1:0] ram_addr_din,
    output logic [8:0]     ram_din,
    output logic           ram_en_dout,
    output logic [Bit-1:0] ram_addr_dout,
    input  logic [8:0]     ram_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]     r_state;
    logic [Bit-1:0] r_wr_addr;
    logic [Bit:0]   r_seq_len;
    logic           r_rd_err;
    logic           r_last_t;   // 1: traceback was granted most recently
    logic           r_f_pend;   // fill read issued last cycle
    logic           r_t_pend;   // traceback read issued last cycle

    logic           w_accept;
    logic           w_done;
    logic           w_arb_en;
    logic           w_f_gnt;
    logic           w_t_gnt;
    logic           w_any_gnt;
    logic [Bit-1:0] w_rd_addr;
    logic           w_oob;
    logic           w_unused;

    // start takes priority over a load byte offered in the same cycle, so the
    // handshake is withheld rather than letting the byte look accepted.
    assign ld_ready = (r_state == S_LOAD) && !start;
    assign w_accept = ld_valid && ld_ready;
    assign w_done   = w_accept && (ld_last || (r_wr_addr == Bit'(N - 1)));

    // No new reads once a reload has been requested.
    assign w_arb_en = (r_state == S_READY) && !start;

    always_comb begin
        w_f_gnt = 1'b0;
        w_t_gnt = 1'b0;
        if (w_arb_en) begin
            if (f_req && t_req) begin
                // Round-robin on a tie: whoever was not granted last wins.
                if (r_last_t) begin
                    w_f_gnt = 1'b1;
                end else begin
                    w_t_gnt = 1'b1;
                end
            end else begin
                w_f_gnt = f_req;
                w_t_gnt = t_req;
            end
        end
    end

    assign w_any_gnt = w_f_gnt || w_t_gnt;
    assign w_rd_addr = w_t_gnt ? t_addr : f_addr;
    assign w_oob     = w_any_gnt && ({1'b0, w_rd_addr} >= r_seq_len);

    assign f_gnt = w_f_gnt;
    assign t_gnt = w_t_gnt;

    // RAM write port: combinational from the load handshake.
    assign ram_en_din   = w_accept;
    assign ram_we       = w_accept;
    assign ram_addr_din = w_accept ? r_wr_addr : '0;
    assign ram_din      = w_accept ? {1'b0, ld_data} : '0;

    // RAM read port: out-of-range addresses are still issued, only flagged.
    assign ram_en_dout   = w_any_gnt;
    assign ram_addr_dout = w_any_gnt ? w_rd_addr : '0;

    // Read data is steered to the requester whose read is returning and held
    // at zero otherwise so an idle channel never shows stale RAM output.
    assign f_rvalid = r_f_pend;
    assign t_rvalid = r_t_pend;
    assign f_rdata  = r_f_pend ? ram_dout[7:0] : '0;
    assign t_rdata  = r_t_pend ? ram_dout[7:0] : '0;

    assign seq_loaded = (r_state == S_READY);
    assign seq_len    = r_seq_len;
    assign rd_err     = r_rd_err;

    // The RAM's ninth bit is never written as 1 and carries no information.
    assign w_unused = ram_dout[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wr_addr <= '0;
            r_seq_len <= '0;
            r_rd_err  <= 1'b0;
            r_last_t  <= 1'b1;
            r_f_pend  <= 1'b0;
            r_t_pend  <= 1'b0;
        end else begin
            // A read granted in the same cycle as start is not possible, but a
            // read granted the cycle before still returns normally.
            r_f_pend <= w_f_gnt;
            r_t_pend <= w_t_gnt;
            if (w_any_gnt) begin
                r_last_t <= w_t_gnt;
            end

            if (start) begin
                r_state   <= S_LOAD;
                r_wr_addr <= '0;
                r_seq_len <= '0;
                r_rd_err  <= 1'b0;
            end else begin
                if (w_oob) begin
                    r_rd_err <= 1'b1;
                end
                if (w_accept) begin
                    r_wr_addr <= r_wr_addr + Bit'(1);
                    r_seq_len <= r_seq_len + (Bit + 1)'(1);
                end
                if (w_done) begin
                    r_state <= S_READY;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_ram_ctrl
//
// Self-checking bench for seq_ram_ctrl. Inputs change on the falling edge,
// combinational outputs are checked 1 ns later, and returned read data is
// checked 1 ns after each rising edge against a queue of expected reads.
// ---------------------------------------------------------------------------
module tb_seq_ram_ctrl;

    localparam int N  = 128;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, ld_valid, ld_last, ld_ready, seq_loaded;
    logic [7:0]    ld_data;
    logic [AW:0]   seq_len;
    logic          f_req, t_req, f_gnt, t_gnt, f_rvalid, t_rvalid, rd_err;
    logic [AW-1:0] f_addr, t_addr;
    logic [7:0]    f_rdata, t_rdata;
    logic          ram_en_din, ram_we, ram_en_dout;
    logic [AW-1:0] ram_addr_din, ram_addr_dout;
    logic [8:0]    ram_din;
    logic [8:0]    ram_dout = '0;

    always #5 clk = ~clk;

    seq_ram_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .seq_loaded(seq_loaded), .seq_len(seq_len),
        .f_req(f_req), .f_addr(f_addr), .t_req(t_req), .t_addr(t_addr),
        .f_gnt(f_gnt), .t_gnt(t_gnt),
        .f_rvalid(f_rvalid), .t_rvalid(t_rvalid),
        .f_rdata(f_rdata), .t_rdata(t_rdata), .rd_err(rd_err),
        .ram_en_din(ram_en_din), .ram_we(ram_we),
        .ram_addr_din(ram_addr_din), .ram_din(ram_din),
        .ram_en_dout(ram_en_dout), .ram_addr_dout(ram_addr_dout),
        .ram_dout(ram_dout)
    );

    // Behavioural sequence RAM with a registered read port.
    logic [8:0] mem [0:N-1];
    always @(posedge clk) begin
        if (ram_en_din && ram_we) mem[ram_addr_din] <= ram_din;
        if (ram_en_dout) ram_dout <= mem[ram_addr_dout];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected read returns.
    typedef struct {
        logic       is_t;
        logic       chkdata;
        logic [7:0] data;
    } rd_t;
    rd_t sbq[$];
    rd_t mon_e;

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("f_rvalid", int'(f_rvalid), int'(!mon_e.is_t));
            chk("t_rvalid", int'(t_rvalid), int'(mon_e.is_t));
            if (mon_e.chkdata)
                chk(mon_e.is_t ? "t_rdata" : "f_rdata",
                    int'(mon_e.is_t ? t_rdata : f_rdata), int'(mon_e.data));
        end else begin
            chk("f_rvalid_idle", int'(f_rvalid), 0);
            chk("t_rvalid_idle", int'(t_rvalid), 0);
        end
    end

    typedef struct {
        logic          fr;
        logic [AW-1:0] fa;
        logic          tr;
        logic [AW-1:0] ta;
        logic          efg;
        logic          etg;
    } vec_t;

    function automatic vec_t mkv(logic fr, int fa, logic tr, int ta, logic efg, logic etg);
        vec_t v;
        v.fr = fr; v.fa = AW'(fa); v.tr = tr; v.ta = AW'(ta);
        v.efg = efg; v.etg = etg;
        return v;
    endfunction

    vec_t       vecs [9];
    logic [7:0] ctgat [5];
    logic [7:0] pat [N];

    task automatic idle_in();
        start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        f_req = 1'b0; f_addr = '0; t_req = 1'b0; t_addr = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ld_ready"},   int'(ld_ready), 0);
        chk({tag, "_seq_loaded"}, int'(seq_loaded), 0);
        chk({tag, "_seq_len"},    int'(seq_len), 0);
        chk({tag, "_f_gnt"},      int'(f_gnt), 0);
        chk({tag, "_t_gnt"},      int'(t_gnt), 0);
        chk({tag, "_f_rvalid"},   int'(f_rvalid), 0);
        chk({tag, "_t_rvalid"},   int'(t_rvalid), 0);
        chk({tag, "_f_rdata"},    int'(f_rdata), 0);
        chk({tag, "_t_rdata"},    int'(t_rdata), 0);
        chk({tag, "_rd_err"},     int'(rd_err), 0);
        chk({tag, "_ram_en_din"}, int'(ram_en_din), 0);
        chk({tag, "_ram_we"},     int'(ram_we), 0);
        chk({tag, "_ram_addr_din"}, int'(ram_addr_din), 0);
        chk({tag, "_ram_din"},    int'(ram_din), 0);
        chk({tag, "_ram_en_dout"}, int'(ram_en_dout), 0);
        chk({tag, "_ram_addr_dout"}, int'(ram_addr_dout), 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        idle_in();
        start = 1'b1;
        #1;
        chk("start_ld_ready", int'(ld_ready), 0);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last, input int idx);
        @(negedge clk);
        idle_in();
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        #1;
        chk("ld_ready", int'(ld_ready), 1);
        chk("ram_we", int'(ram_we && ram_en_din), 1);
        chk("ram_addr_din", int'(ram_addr_din), idx);
        chk("ram_din", int'(ram_din), int'({1'b0, d}));
    endtask

    // Single read expected to be granted to one requester.
    task automatic read_one(input logic is_t, input int addr, input logic [7:0] exp);
        rd_t e;
        @(negedge clk);
        idle_in();
        if (is_t) begin t_req = 1'b1; t_addr = AW'(addr); end
        else begin f_req = 1'b1; f_addr = AW'(addr); end
        #1;
        chk("rd_f_gnt", int'(f_gnt), int'(!is_t));
        chk("rd_t_gnt", int'(t_gnt), int'(is_t));
        chk("rd_ram_addr_dout", int'(ram_addr_dout), addr);
        e.is_t = is_t; e.chkdata = 1'b1; e.data = exp;
        sbq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_t e;
        for (int i = 0; i < N; i++) mem[i] = '0;
        ctgat[0] = 8'h43; ctgat[1] = 8'h54; ctgat[2] = 8'h47;
        ctgat[3] = 8'h41; ctgat[4] = 8'h54;
        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0: pat[i] = 8'h41;
                1: pat[i] = 8'h43;
                2: pat[i] = 8'h47;
                default: pat[i] = 8'h54;
            endcase
        end
        // fr fa tr ta  efg etg ; last-grant starts as trace
        vecs[0] = mkv(1, 2, 0, 0, 1, 0);
        vecs[1] = mkv(0, 0, 1, 1, 0, 1);
        vecs[2] = mkv(0, 0, 0, 0, 0, 0);
        vecs[3] = mkv(1, 0, 1, 4, 1, 0);
        vecs[4] = mkv(1, 0, 1, 4, 0, 1);
        vecs[5] = mkv(1, 0, 1, 4, 1, 0);
        vecs[6] = mkv(1, 0, 1, 4, 0, 1);
        vecs[7] = mkv(1, 4, 0, 0, 1, 0);
        vecs[8] = mkv(0, 0, 1, 0, 0, 1);

        // Reset state.
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Requests in IDLE are ignored.
        f_req = 1'b1; t_req = 1'b1;
        #1;
        chk("idle_f_gnt", int'(f_gnt), 0);
        chk("idle_t_gnt", int'(t_gnt), 0);

        // Load "CTGAT" with ld_last on the fifth byte.
        do_start();
        for (int i = 0; i < 5; i++) load_byte(ctgat[i], (i == 4), i);

        // Table-driven arbitration; the first vector lands in the cycle that
        // seq_loaded first rises.
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            idle_in();
            f_req = vecs[n].fr; f_addr = vecs[n].fa;
            t_req = vecs[n].tr; t_addr = vecs[n].ta;
            #1;
            if (n == 0) begin
                chk("ctgat_seq_loaded", int'(seq_loaded), 1);
                chk("ctgat_seq_len", int'(seq_len), 5);
                chk("ctgat_ld_ready", int'(ld_ready), 0);
            end
            chk($sformatf("vec%0d_f_gnt", n), int'(f_gnt), int'(vecs[n].efg));
            chk($sformatf("vec%0d_t_gnt", n), int'(t_gnt), int'(vecs[n].etg));
            chk($sformatf("vec%0d_ram_en_dout", n), int'(ram_en_dout),
                int'(vecs[n].efg || vecs[n].etg));
            if (vecs[n].efg || vecs[n].etg) begin
                e.is_t = vecs[n].etg;
                e.chkdata = 1'b1;
                e.data = vecs[n].etg ? ctgat[vecs[n].ta] : ctgat[vecs[n].fa];
                chk($sformatf("vec%0d_ram_addr_dout", n), int'(ram_addr_dout),
                    int'(vecs[n].etg ? vecs[n].ta : vecs[n].fa));
                sbq.push_back(e);
            end
            chk($sformatf("vec%0d_rd_err", n), int'(rd_err), 0);
        end

        // Out-of-range read is issued and sets sticky rd_err.
        @(negedge clk);
        idle_in();
        t_req = 1'b1; t_addr = 7'd6;
        #1;
        chk("oob_t_gnt", int'(t_gnt), 1);
        chk("oob_ram_addr_dout", int'(ram_addr_dout), 6);
        e.is_t = 1'b1; e.chkdata = 1'b0; e.data = '0;
        sbq.push_back(e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_in();
            #1;
            chk("oob_rd_err_sticky", int'(rd_err), 1);
        end

        // start in READY with a read returning: the return still happens and
        // the concurrent request is not granted.
        read_one(1'b0, 3, 8'h41);
        @(negedge clk);
        idle_in();
        start = 1'b1; t_req = 1'b1; t_addr = 7'd0;
        #1;
        chk("start_t_gnt", int'(t_gnt), 0);
        chk("start_ram_en_dout", int'(ram_en_dout), 0);
        @(negedge clk);
        idle_in();
        #1;
        chk("restart_seq_loaded", int'(seq_loaded), 0);
        chk("restart_seq_len", int'(seq_len), 0);
        chk("restart_rd_err", int'(rd_err), 0);
        chk("restart_ld_ready", int'(ld_ready), 1);

        // start and ld_valid together: start wins, nothing written.
        start = 1'b1; ld_valid = 1'b1; ld_data = 8'hFF;
        #1;
        chk("start_vs_ld_ram_en_din", int'(ram_en_din), 0);
        chk("start_vs_ld_ld_ready", int'(ld_ready), 0);

        // Full 128-byte load without ld_last.
        for (int i = 0; i < N; i++) load_byte(pat[i], 1'b0, i);
        @(negedge clk);
        idle_in();
        ld_valid = 1'b1; ld_data = 8'h58;
        #1;
        chk("full_seq_loaded", int'(seq_loaded), 1);
        chk("full_seq_len", int'(seq_len), 128);
        chk("full_extra_ld_ready", int'(ld_ready), 0);
        chk("full_extra_ram_en_din", int'(ram_en_din), 0);
        read_one(1'b0, 127, pat[127]);
        read_one(1'b1, 0, pat[0]);
        @(negedge clk);
        idle_in();
        #1;
        chk("full_rd_err", int'(rd_err), 0);

        // Reset in the middle of a load.
        do_start();
        for (int i = 0; i < 3; i++) load_byte(ctgat[i], 1'b0, i);
        @(negedge clk);
        idle_in();
        ld_valid = 1'b1; ld_data = ctgat[3];
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check_all_zero("midload_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f_req = 1'b1; t_req = 1'b1; ld_valid = 1'b1;
            #1;
            chk("post_rst_f_gnt", int'(f_gnt), 0);
            chk("post_rst_t_gnt", int'(t_gnt), 0);
            chk("post_rst_ld_ready", int'(ld_ready), 0);
        end
        do_start();
        load_byte(8'h47, 1'b0, 0);
        load_byte(8'h41, 1'b1, 1);
        read_one(1'b0, 1, 8'h41);
        @(negedge clk);
        idle_in();
        #1;
        chk("reload_seq_len", int'(seq_len), 2);

        // A grant cut off by reset before its clock edge never returns data.
        @(negedge clk);
        f_req = 1'b1; f_addr = 7'd0;
        #1;
        chk("discard_f_gnt", int'(f_gnt), 1);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("discard_f_gnt_rst", int'(f_gnt), 0);
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_ram_ctrl.md
# seq_ram_ctrl

Controller for one sequence RAM (A or B) of the Needleman-Wunsch engine. It owns the RAM's write port and sequences the loading of one sequence, byte by byte. It arbitrates the RAM's single registered read port between the matrix-fill engine and the traceback engine, and returns the read data tagged to whichever requester was granted. One instance sits between each sequence RAM and the fill/traceback datapath.

## Interface
- N, 128, sequence RAM depth (maximum sequence length).
- Bit, $clog2(N), RAM address width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse that begins a new sequence load.
- ld_valid  in  1  loader has a byte on ld_data.
- ld_data  in  8  ASCII nucleotide to store.
- ld_last  in  1  qualifies ld_valid: this byte is the final one.
- ld_ready  out  1  controller accepts a load byte this cycle.
- seq_loaded  out  1  a sequence is stored; reads are allowed.
- seq_len  out  Bit+1  number of bytes stored (1..N).
- f_req, t_req  in  1  fill / traceback read request.
- f_addr, t_addr  in  Bit  fill / traceback read address.
- f_gnt, t_gnt  out  1  request granted this cycle (combinational).
- f_rvalid, t_rvalid  out  1  read data valid for fill / traceback.
- f_rdata, t_rdata  out  8  read data (ram_dout[7:0]).
- rd_err  out  1  sticky: a granted address was >= seq_len.
- ram_en_din, ram_we  out  1  RAM write enable pair.
- ram_addr_din  out  Bit  RAM write address.
- ram_din  out  9  RAM write data, {1'b0, ld_data}.
- ram_en_dout  out  1  RAM read enable.
- ram_addr_dout  out  Bit  RAM read address.
- ram_dout  in  9  RAM registered read data (valid 1 cycle after ram_en_dout).

## Operation
- States: IDLE (entered on reset), LOAD, READY.
- IDLE: ld_ready=0, no grants. start moves the FSM to LOAD, clears wr_addr, seq_len and rd_err.
- LOAD:
  - ld_ready=1.
  - Each ld_valid&&ld_ready cycle drives ram_en_din=ram_we=1, ram_addr_din=wr_addr, ram_din={0,ld_data}, then wr_addr++ and seq_len++.
  - The FSM moves to READY after the accepted byte that has ld_last=1, or after the accepted byte at wr_addr==N-1, whichever comes first.
  - No grants are issued in LOAD.
- READY:
  - seq_loaded=1, ld_ready=0.
  - Read arbitration is enabled.
  - start returns the FSM to LOAD: seq_loaded drops, seq_len and rd_err clear, the RAM contents are overwritten.
- start received in LOAD restarts the load at address 0.
- Arbitration (READY only), at most one grant per cycle:
  - Only one requester asserting its req: that requester is granted.
  - Both asserting: round-robin. The requester not granted last is granted. The last-grant register resets to "trace", so fill wins the first tie.
  - On a grant: ram_en_dout=1 and ram_addr_dout = the granted address. A requester holds req and addr stable until its gnt.
- Read return: the granted requester's rvalid=1 exactly one cycle after its gnt, with rdata=ram_dout[7:0]. The other requester's rvalid stays 0.
- Address check: a granted address >= seq_len is still issued to the RAM, and rd_err sets. rd_err clears only on start or reset.
- ram_din[8] is always 0.

## Timing
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: ld_ready, seq_loaded, seq_len, gnts, rvalids, rdata, rd_err, and all ram_* outputs. wr_addr=0, last-grant=trace. Any in-flight read is discarded: no rvalid after reset release.
- Write latency: 0. RAM strobes are combinational from the ld_valid&&ld_ready handshake; the counters update on the same edge.
- Read latency: gnt at cycle k, rvalid/rdata at cycle k+1. Back-to-back grants sustain 1 read/cycle.
- seq_loaded rises the cycle after the final byte is accepted; the first grant is possible in that same cycle.
- start in READY with a read pending return: that cycle's rvalid still occurs; no new grants are issued.
- start and ld_valid in the same cycle: start wins and the byte is not written.

## Test plan
- Load "CTGAT" (43,54,47,41,54) with ld_last on byte 5 -> RAM addresses 0..4 written with ram_din=0x043.., seq_len=5, seq_loaded=1 the next cycle.
- Load 128 bytes with no ld_last -> FSM enters READY after address 127, seq_len=128; a 129th ld_valid is ignored (ld_ready=0).
- READY: f_req addr 2 alone -> f_gnt the same cycle, f_rvalid the next cycle with f_rdata=0x47; t_rvalid=0.
- Both requesting for 4 cycles (f addr 0, t addr 4) -> grants F,T,F,T; rdata 0x43/0x54 returned to the matching requester each next cycle.
- t_req addr 6 with seq_len=5 -> granted, rd_err=1, stays 1 until start; start clears seq_len to 0 and seq_loaded to 0.
- rst_n low mid-load (after 3 bytes) -> all outputs 0 immediately; after release the FSM is in IDLE, grants stay 0 until start and a new load.
